// File: rtl/sensor_seq_gen.sv
// sensor_seq_gen: transmit end of the two-line sensor protocol.
// Accepts up/down commands over valid/ready and walks the sensor lines
// through the 4-phase Gray sequence, each phase held DWELL_CYCLES cycles,
// while tracking the count the downstream counter should reach.
// Optional macro SEQ_ABORT_EN: abort in PH1..PH3 retreats through the
// visited phases in reverse and returns to IDLE without counting.
module sensor_seq_gen #(
  parameter int unsigned DWELL_CYCLES = 100,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  output logic             req_ready,
  input  logic             abort,
  output logic [1:0]       sens,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_count,
  output logic [2:0]       debug_state
);

  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW-1:0] RELOAD = DW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    PH1     = 3'b001,
    PH2     = 3'b010,
    PH3     = 3'b011,
    GAP     = 3'b100,
    RETREAT = 3'b101
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DW-1:0]     dwell_q;
  logic              dwell_end;
  logic              dir_q;
  logic              accept;
  logic              abort_hit;
  logic              done_q;
  logic [CNT_W-1:0]  count_q;

  // Sensor pattern for phase depth lvl (1..3) of an up or down sweep.
  function automatic logic [1:0] phase_pat(input logic [1:0] lvl, input logic up);
    logic [1:0] p;
    p = 2'b00;
    case (lvl)
      2'd1:    p = up ? 2'b01 : 2'b10;
      2'd2:    p = 2'b11;
      2'd3:    p = up ? 2'b10 : 2'b01;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  assign dwell_end = (dwell_q == '0);
  assign accept    = req_valid && req_ready;

`ifdef SEQ_ABORT_EN
  logic [1:0] rlevel_q;

  assign abort_hit = abort && (state == PH1 || state == PH2 || state == PH3);

  // Retreat depth: captured on abort, stepped down as each replayed phase expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rlevel_q <= '0;
    end else if (abort_hit) begin
      // PH1..PH3 encodings equal their depth in the sequence
      rlevel_q <= state[1:0];
    end else if (state == RETREAT && dwell_end) begin
      rlevel_q <= rlevel_q - 2'd1;
    end
  end
`else
  logic abort_unused;

  assign abort_unused = abort;
  assign abort_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: abort takes priority over normal phase advance.
  always_comb begin
    state_nx = state;
    if (abort_hit) begin
      state_nx = RETREAT;
    end else begin
      case (state)
        IDLE:    if (accept)    state_nx = PH1;
        PH1:     if (dwell_end) state_nx = PH2;
        PH2:     if (dwell_end) state_nx = PH3;
        PH3:     if (dwell_end) state_nx = GAP;
        GAP:     if (dwell_end) state_nx = IDLE;
`ifdef SEQ_ABORT_EN
        RETREAT: if (dwell_end && rlevel_q == 2'd1) state_nx = IDLE;
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode from state, latched direction and retreat depth.
  always_comb begin
    sens = 2'b00;
    case (state)
      PH1:     sens = phase_pat(2'd1, dir_q);
      PH2:     sens = phase_pat(2'd2, dir_q);
      PH3:     sens = phase_pat(2'd3, dir_q);
`ifdef SEQ_ABORT_EN
      RETREAT: sens = phase_pat(rlevel_q, dir_q);
`endif
      default: sens = 2'b00;
    endcase
    busy        = (state != IDLE);
    req_ready   = (state == IDLE) && reset;
    debug_state = state;
    done        = done_q;
    exp_count   = count_q;
  end

  // Dwell timer: reloads on every phase entry, including each retreat step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q <= RELOAD;
    end else if (state_nx != state || dwell_end) begin
      dwell_q <= RELOAD;
    end else begin
      dwell_q <= dwell_q - DW'(1);
    end
  end

  // Direction latch on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      dir_q <= 1'b0;
    else if (accept) dir_q <= req_dir;
  end

  // Completion pulse and shadow count, both updated on the GAP->IDLE edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= (state == GAP) && dwell_end;
      if (state == GAP && dwell_end) begin
        count_q <= dir_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end
    end
  end

endmodule
